// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel shifter / normalizer family:
// shift-mode encoding and the normalizer FSM state encoding.
package barrel_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STEP = 2'b01,
        ST_DONE = 2'b10
    } norm_state_t;

endpackage

// File: rtl/barrel_normalizer_norm_step.sv
// Single-position shift/rotate selected by mode, plus a flag telling whether
// the current word already meets the termination condition for that mode.
module norm_step
    import barrel_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] word_i,
    input  logic [1:0]   mode_i,
    output logic [N-1:0] next_o,
    output logic         done_o
);

    always_comb begin
        next_o = word_i;
        case (mode_i)
            MODE_SLL: next_o = {word_i[N-2:0], 1'b0};
            MODE_SRL: next_o = {1'b0, word_i[N-1:1]};
            MODE_ROL: next_o = {word_i[N-2:0], word_i[N-1]};
            MODE_ROR: next_o = {word_i[0], word_i[N-1:1]};
            default:  next_o = word_i;
        endcase
    end

    // Right-moving modes (odd encodings) stop on the LSB, left-moving on the MSB.
    assign done_o = mode_i[0] ? word_i[0] : word_i[N-1];

endmodule

// File: rtl/barrel_normalizer.sv
// Multi-cycle normalizer: shifts/rotates one position per cycle until the word
// is normalized, then presents the word and step count behind valid/ready.
module barrel_normalizer
    import barrel_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  data,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out,
    output logic [SW-1:0] shift,
    output logic          zero
);

    norm_state_t   state_q;
    logic [N-1:0]  word_q;
    logic [1:0]    mode_q;
    logic [SW-1:0] count_q;
    logic          zeroFlag_q;
    logic          inReady_q;
    logic          outValid_q;

    logic [N-1:0]  shiftedWord_d;
    logic          stepDone;

    norm_step #(.N(N)) u_step (
        .word_i (word_q),
        .mode_i (mode_q),
        .next_o (shiftedWord_d),
        .done_o (stepDone)
    );

    // A non-zero word needs at most N-1 steps, so count_q never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            mode_q     <= MODE_SLL;
            count_q    <= '0;
            zeroFlag_q <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_q     <= data;
                        mode_q     <= mode;
                        count_q    <= '0;
                        zeroFlag_q <= 1'b0;
                        inReady_q  <= 1'b0;
                        state_q    <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (word_q == '0) begin
                        zeroFlag_q <= 1'b1;
                        outValid_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (stepDone) begin
                        outValid_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        word_q  <= shiftedWord_d;
                        count_q <= count_q + SW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out       = word_q;
    assign shift     = count_q;
    assign zero      = zeroFlag_q;

endmodule

// File: tb/tb_barrel_normalizer.sv
// Self-checking bench for barrel_normalizer: directed scenarios followed by
// randomized requests, all checked against a zero-counting reference model.
module tb_barrel_normalizer;

    localparam int N  = 4;
    localparam int SW = $clog2(N);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  data;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out;
    logic [SW-1:0] shift;
    logic          zero;

    int compareCount;
    int mismatchCount;

    barrel_normalizer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .shift     (shift),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the step count is the number of leading (left modes) or
    // trailing (right modes) zeros; the result is one multi-bit shift/rotate.
    function automatic void refModel(input logic [N-1:0] d, input logic [1:0] m,
                                     output logic [N-1:0] o, output int s, output bit z);
        z = (d == '0);
        s = 0;
        o = d;
        if (!z) begin
            if (m[0] == 1'b0) begin
                while (d[N-1-s] == 1'b0) s++;
            end else begin
                while (d[s] == 1'b0) s++;
            end
            case (m)
                2'b00:   o = d << s;
                2'b01:   o = d >> s;
                2'b10:   o = (d << s) | (d >> (N - s));
                default: o = (d >> s) | (d << (N - s));
            endcase
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one request for a single edge, then scramble the inputs so a
    // design that re-samples data or mode after accept is exposed.
    task automatic applyStimulus(input logic [N-1:0] d, input logic [1:0] m);
        checkOutput("accept_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data     = d;
        mode     = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data     = N'($urandom);
        mode     = ~m;
    endtask

    task automatic runRequest(input string tag, input logic [N-1:0] d,
                              input logic [1:0] m, input int holdCycles);
        logic [N-1:0] expOut;
        int           expShift;
        bit           expZero;
        int           lat;
        refModel(d, m, expOut, expShift, expZero);
        applyStimulus(d, m);
        lat = 0;
        for (int c = 1; c <= N + 4; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expShift + 1));
        checkOutput({tag, "_out"}, 32'(out), 32'(expOut));
        checkOutput({tag, "_shift"}, 32'(shift), 32'(expShift));
        checkOutput({tag, "_zero"}, 32'(zero), 32'(expZero));
        checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < holdCycles; h++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_hold_out"}, 32'(out), 32'(expOut));
            checkOutput({tag, "_hold_shift"}, 32'(shift), 32'(expShift));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_release_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data      = '0;
        mode      = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out", 32'(out), 32'd0);
        checkOutput("reset_shift", 32'(shift), 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd0);
        rst = 1'b0;

        $display("[TB] directed normalization cases");
        runRequest("sll_0010", 4'b0010, 2'b00, 0);
        runRequest("sll_1001", 4'b1001, 2'b00, 0);
        runRequest("srl_0100", 4'b0100, 2'b01, 0);
        runRequest("ror_1000", 4'b1000, 2'b11, 0);
        runRequest("rol_0101", 4'b0101, 2'b10, 0);
        runRequest("rol_0011", 4'b0011, 2'b10, 0);
        for (int m = 0; m < 4; m++) begin
            runRequest("zero_word", 4'b0000, 2'(m), 0);
        end

        $display("[TB] backpressure with a competing request");
        applyStimulus(4'b0010, 2'b11);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        data     = 4'b1111;
        mode     = 2'b11;
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_out", 32'(out), 32'b0001);
            checkOutput("bp_hold_shift", 32'(shift), 32'd1);
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp_second_accepted", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("bp_second_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_second_out", 32'(out), 32'b1111);
        checkOutput("bp_second_shift", 32'(shift), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_second_release", 32'(in_ready), 32'd1);

        $display("[TB] reset in the middle of stepping");
        applyStimulus(4'b1000, 2'b01);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out", 32'(out), 32'd0);
        checkOutput("midrst_shift", 32'(shift), 32'd0);
        runRequest("after_rst_sll_0001", 4'b0001, 2'b00, 0);

        $display("[TB] randomized requests");
        for (int i = 0; i < 40; i++) begin
            runRequest("rand", N'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
